// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port RAM between instruction fetch, load and
// store. It grants one access per cycle and tracks the one-cycle read latency.
//
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   if_req/if_addr/if_ack/if_data fetch read channel
//   ld_req/ld_addr/ld_ack/ld_data load read channel (raw word)
//   st_req/st_mode/st_addr/st_data/st_ack  store channel
//   ram_addr/ram_write_mode/ram_write_data/ram_read_data  RAM macro side
//   busy                          a read is outstanding
//
// Build option: define RAM_ARB_FAIR_EN to let fetch override data traffic
// after MAX_DATA_BURST consecutive data grants. Without it, priority is
// strictly store > load > fetch.
//
// Grants, store ack and RAM write controls are combinational in the grant
// cycle. This is the zero-latency store path the pipeline relies on.
module ram_arbiter #(
   parameter int unsigned XLEN           = 32,
   parameter int unsigned MAX_DATA_BURST = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            if_req,
   input  logic [XLEN-1:0] if_addr,
   output logic            if_ack,
   output logic [XLEN-1:0] if_data,
   input  logic            ld_req,
   input  logic [XLEN-1:0] ld_addr,
   output logic            ld_ack,
   output logic [XLEN-1:0] ld_data,
   input  logic            st_req,
   input  logic [1:0]      st_mode,
   input  logic [XLEN-1:0] st_addr,
   input  logic [XLEN-1:0] st_data,
   output logic            st_ack,
   output logic [XLEN-1:0] ram_addr,
   output logic [1:0]      ram_write_mode,
   output logic [XLEN-1:0] ram_write_data,
   input  logic [XLEN-1:0] ram_read_data,
   output logic            busy
);

   localparam int unsigned CNT_W = 4;

   // Elaboration-time range check on the burst limit.
   if (MAX_DATA_BURST < 1 || MAX_DATA_BURST > 15) begin : g_bad_burst
      $error("ram_arbiter: MAX_DATA_BURST must be in 1..15");
   end

   typedef enum logic {S_IDLE, S_RD_PEND} state_t;
   typedef enum logic {OWN_IF, OWN_LD} owner_t;

   state_t          state_q, state_d;
   owner_t          owner_q, owner_d;
   logic [XLEN-1:0] ram_addr_q, ram_addr_d;

   logic gnt_st, gnt_ld, gnt_if;
   logic fair_force;
   logic rd_done;

`ifdef RAM_ARB_FAIR_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Fetch wins once data traffic has used up its burst allowance.
   assign fair_force = if_req && (cnt_q == CNT_W'(MAX_DATA_BURST));

   // Consecutive data grants while fetch waits; cleared when fetch is served or idle.
   always_comb begin
      cnt_d = cnt_q;
      if (rst && state_q == S_IDLE) begin
         if (!if_req || gnt_if) begin
            cnt_d = '0;
         end else if (gnt_st || gnt_ld) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   assign fair_force = 1'b0;
`endif

   // Grant selection. Only issued in IDLE, and suppressed while reset is held.
   always_comb begin
      gnt_st = 1'b0;
      gnt_ld = 1'b0;
      gnt_if = 1'b0;
      if (rst && state_q == S_IDLE) begin
         if (fair_force) begin
            gnt_if = 1'b1;
         end else if (st_req) begin
            gnt_st = 1'b1;
         end else if (ld_req) begin
            gnt_ld = 1'b1;
         end else if (if_req) begin
            gnt_if = 1'b1;
         end
      end
   end

   // Next state, read owner and held RAM address.
   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      ram_addr_d = ram_addr_q;
      case (state_q)
         S_IDLE: begin
            if (gnt_ld || gnt_if) begin
               state_d = S_RD_PEND;
               owner_d = gnt_ld ? OWN_LD : OWN_IF;
            end
         end
         S_RD_PEND: state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
      if (gnt_st) begin
         ram_addr_d = st_addr;
      end else if (gnt_ld) begin
         ram_addr_d = ld_addr;
      end else if (gnt_if) begin
         ram_addr_d = if_addr;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         owner_q    <= OWN_IF;
         ram_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         ram_addr_q <= ram_addr_d;
      end
   end

   // RAM side: the address follows the grant, otherwise it holds.
   assign ram_addr       = ram_addr_d;
   assign ram_write_mode = gnt_st ? st_mode : 2'b00;
   assign ram_write_data = gnt_st ? st_data : '0;

   // Requester side: read data is forwarded only in the owner's ack cycle.
   assign rd_done = (state_q == S_RD_PEND);
   assign busy    = rd_done;
   assign st_ack  = gnt_st;
   assign if_ack  = rd_done && (owner_q == OWN_IF);
   assign ld_ack  = rd_done && (owner_q == OWN_LD);
   assign if_data = if_ack ? ram_read_data : '0;
   assign ld_data = ld_ack ? ram_read_data : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed self-checking bench for ram_arbiter, with a small
// behavioural RAM (one-cycle read latency, byte/half/word writes).
//
// Inputs are driven 1 time unit after the rising edge. Outputs are sampled
// 1 time unit later, while still in the same cycle.
module tb_ram_arbiter;

   localparam int unsigned XLEN = 32;

   logic            clk = 1'b0;
   logic            rst;
   logic            if_req, ld_req, st_req;
   logic [XLEN-1:0] if_addr, ld_addr, st_addr, st_data;
   logic [1:0]      st_mode;
   logic            if_ack, ld_ack, st_ack, busy;
   logic [XLEN-1:0] if_data, ld_data;
   logic [XLEN-1:0] ram_addr, ram_write_data, ram_read_data;
   logic [1:0]      ram_write_mode;

   int checks = 0;
   int errors = 0;

   logic [31:0] mem [0:255];

   always #5 clk = ~clk;

   ram_arbiter #(.XLEN(XLEN), .MAX_DATA_BURST(4)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_data(if_data),
      .ld_req(ld_req), .ld_addr(ld_addr), .ld_ack(ld_ack), .ld_data(ld_data),
      .st_req(st_req), .st_mode(st_mode), .st_addr(st_addr), .st_data(st_data),
      .st_ack(st_ack),
      .ram_addr(ram_addr), .ram_write_mode(ram_write_mode),
      .ram_write_data(ram_write_data), .ram_read_data(ram_read_data),
      .busy(busy)
   );

   // Synchronous RAM with word-indexed storage.
   always @(posedge clk) begin
      case (ram_write_mode)
         2'b01: mem[ram_addr[9:2]][{ram_addr[1:0], 3'b000} +: 8] <= ram_write_data[7:0];
         2'b10: mem[ram_addr[9:2]][{ram_addr[1], 4'b0000} +: 16] <= ram_write_data[15:0];
         2'b11: mem[ram_addr[9:2]] <= ram_write_data;
         default: ;
      endcase
      ram_read_data <= mem[ram_addr[9:2]];
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      if_req = 1'b0; ld_req = 1'b0; st_req = 1'b0;
      if_addr = '0; ld_addr = '0; st_addr = '0; st_data = '0; st_mode = 2'b00;
   endtask

   task automatic test_reset();
      logic [3*XLEN+7:0] obs;
      rst = 1'b0;
      idle_inputs();
      repeat (3) next_cycle();
      rst = 1'b1;
      for (int i = 0; i < 10; i++) begin
         next_cycle();
         #1;
         obs = {if_ack, ld_ack, st_ack, busy, ram_write_mode, 2'b00,
                if_data, ld_data, ram_addr};
         checks++;
         if (obs !== '0 || ram_write_data !== '0) begin
            errors++;
            $display("FAIL reset_idle cycle %0d: got %h wd %h, expected all zero", i, obs, ram_write_data);
         end
      end
   endtask

   task automatic test_fetch();
      mem[8'h40] = 32'hDEADBEEF;   // byte address 0x100
      next_cycle();
      if_req = 1'b1; if_addr = 32'h100;
      #1;
      checks++;
      if (ram_addr !== 32'h100 || busy !== 1'b0 || if_ack !== 1'b0 || ram_write_mode !== 2'b00) begin
         errors++;
         $display("FAIL fetch_grant: addr %h busy %b ack %b mode %b, expected 100 0 0 00",
                  ram_addr, busy, if_ack, ram_write_mode);
      end
      next_cycle();
      #1;
      checks++;
      if (if_ack !== 1'b1 || if_data !== 32'hDEADBEEF || busy !== 1'b1 || ld_ack !== 1'b0) begin
         errors++;
         $display("FAIL fetch_ack: ack %b data %h busy %b, expected 1 deadbeef 1", if_ack, if_data, busy);
      end
      next_cycle();
      if_req = 1'b0;
      #1;
      checks++;
      if (if_ack !== 1'b0 || if_data !== '0 || busy !== 1'b0 || ram_addr !== 32'h100) begin
         errors++;
         $display("FAIL fetch_after: ack %b data %h busy %b addr %h, expected 0 0 0 100",
                  if_ack, if_data, busy, ram_addr);
      end
   endtask

   task automatic test_store_then_load();
      next_cycle();
      st_req = 1'b1; st_mode = 2'b11; st_addr = 32'h200; st_data = 32'h12345678;
      ld_req = 1'b1; ld_addr = 32'h200;
      #1;
      checks++;
      if (st_ack !== 1'b1 || ld_ack !== 1'b0 || ram_write_mode !== 2'b11 ||
          ram_addr !== 32'h200 || ram_write_data !== 32'h12345678) begin
         errors++;
         $display("FAIL st_ld_c0: st_ack %b ld_ack %b mode %b addr %h wd %h, expected 1 0 11 200 12345678",
                  st_ack, ld_ack, ram_write_mode, ram_addr, ram_write_data);
      end
      next_cycle();
      st_req = 1'b0; st_mode = 2'b00;
      #1;
      checks++;
      if (st_ack !== 1'b0 || ld_ack !== 1'b0 || busy !== 1'b0 || ram_write_mode !== 2'b00 ||
          ram_addr !== 32'h200 || ram_write_data !== '0) begin
         errors++;
         $display("FAIL st_ld_c1: st_ack %b ld_ack %b busy %b mode %b addr %h wd %h, expected load issue",
                  st_ack, ld_ack, busy, ram_write_mode, ram_addr, ram_write_data);
      end
      next_cycle();
      #1;
      checks++;
      if (ld_ack !== 1'b1 || ld_data !== 32'h12345678 || busy !== 1'b1 || if_ack !== 1'b0) begin
         errors++;
         $display("FAIL st_ld_c2: ld_ack %b ld_data %h busy %b, expected 1 12345678 1", ld_ack, ld_data, busy);
      end
      next_cycle();
      ld_req = 1'b0;
      #1;
      checks++;
      if (ld_ack !== 1'b0 || ld_data !== '0) begin
         errors++;
         $display("FAIL st_ld_after: ld_ack %b ld_data %h, expected 0 0", ld_ack, ld_data);
      end
   endtask

   task automatic test_null_and_byte_store();
      // Mode 00 is acknowledged but must not touch the RAM.
      next_cycle();
      st_req = 1'b1; st_mode = 2'b00; st_addr = 32'h200; st_data = 32'hFFFFFFFF;
      #1;
      checks++;
      if (st_ack !== 1'b1 || ram_write_mode !== 2'b00) begin
         errors++;
         $display("FAIL null_store: st_ack %b mode %b, expected 1 00", st_ack, ram_write_mode);
      end
      next_cycle();
      st_mode = 2'b01; st_addr = 32'h201; st_data = 32'h000000AB;
      #1;
      checks++;
      if (st_ack !== 1'b1 || ram_write_mode !== 2'b01 || ram_addr !== 32'h201) begin
         errors++;
         $display("FAIL byte_store: st_ack %b mode %b addr %h, expected 1 01 201", st_ack, ram_write_mode, ram_addr);
      end
      next_cycle();
      st_req = 1'b0; st_mode = 2'b00;
      ld_req = 1'b1; ld_addr = 32'h200;
      next_cycle();
      #1;
      checks++;
      if (ld_ack !== 1'b1 || ld_data !== 32'h1234AB78) begin
         errors++;
         $display("FAIL store_readback: ld_ack %b ld_data %h, expected 1 1234ab78", ld_ack, ld_data);
      end
      next_cycle();
      ld_req = 1'b0;
   endtask

   task automatic test_reset_mid_read();
      next_cycle();
      ld_req = 1'b1; ld_addr = 32'h200;
      next_cycle();
      // RD_PEND cycle: the reset drops the pending read.
      rst = 1'b0; ld_req = 1'b0;
      #1;
      checks++;
      if (ld_ack !== 1'b0 || busy !== 1'b0 || ld_data !== '0) begin
         errors++;
         $display("FAIL rst_mid_read: ld_ack %b busy %b data %h, expected 0 0 0", ld_ack, busy, ld_data);
      end
      next_cycle();
      rst = 1'b1;
      #1;
      checks++;
      if (ld_ack !== 1'b0 || busy !== 1'b0 || ram_addr !== '0) begin
         errors++;
         $display("FAIL rst_release: ld_ack %b busy %b addr %h, expected 0 0 0", ld_ack, busy, ram_addr);
      end
      next_cycle();
      #1;
      checks++;
      if (ld_ack !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL rst_after: ld_ack %b busy %b, expected 0 0", ld_ack, busy);
      end
   endtask

   task automatic test_fetch_starvation();
      int st_cnt = 0;
      int got_if = 0;
      int multi  = 0;
      next_cycle();
      if_req = 1'b1; if_addr = 32'h100;
      st_req = 1'b1; st_mode = 2'b11;
      for (int i = 0; i < 20 && got_if == 0; i++) begin
         st_addr = 32'h300 + 32'(4 * i);
         st_data = 32'(i);
         #1;
         if (32'(if_ack) + 32'(ld_ack) + 32'(st_ack) > 1) multi++;
         if (if_ack === 1'b1) got_if = 1;
         else if (st_ack === 1'b1) st_cnt++;
         if (got_if == 0) next_cycle();
      end
      checks++;
      if (multi != 0) begin
         errors++;
         $display("FAIL one_ack: %0d cycles with several acks, expected 0", multi);
      end
`ifdef RAM_ARB_FAIR_EN
      checks++;
      if (got_if != 1 || st_cnt != 4) begin
         errors++;
         $display("FAIL fair_fetch: if_ack seen %0d after %0d st_acks, expected 1 after 4", got_if, st_cnt);
      end
      checks++;
      if (if_data !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL fair_fetch_data: got %h expected deadbeef", if_data);
      end
      next_cycle();
      if_req = 1'b0; st_req = 1'b0;
`else
      checks++;
      if (got_if != 0 || st_cnt != 20) begin
         errors++;
         $display("FAIL strict_starve: if_ack seen %0d, st_acks %0d, expected 0 and 20", got_if, st_cnt);
      end
      // Once the store stream stops, fetch is served.
      st_req = 1'b0;
      next_cycle();
      #1;
      checks++;
      if (if_ack !== 1'b1 || if_data !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL strict_fetch_late: ack %b data %h, expected 1 deadbeef", if_ack, if_data);
      end
      next_cycle();
      if_req = 1'b0;
`endif
      st_mode = 2'b00;
      next_cycle();
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = '0;
      test_reset();
      test_fetch();
      test_store_then_load();
      test_null_and_byte_store();
      test_reset_mid_read();
      test_fetch_starvation();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Hard time limit so the bench always ends.
   initial begin
      #100000;
      $display("FAIL timeout: bench did not reach its summary, checks %0d errors %0d", checks, errors);
      $fatal(1, "timeout");
   end

endmodule
